// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter between two requesters.
// Optional per-requester grant counters are built when SHIFT_ARB_STATS_EN is defined.
module shifter (
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [1:0]  c,
  output logic [31:0] z
);
  always_comb begin
    z = a;
    unique case (c)
      2'b00: z = a << b;
      2'b01: z = a >> b;
      2'b10: z = $unsigned($signed(a) >>> b);
      2'b11: z = (a >> b) | (a << (6'd32 - {1'b0, b}));
      default: z = a;
    endcase
  end
endmodule

module shift_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [4:0]       req0_amt,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [4:0]       req1_amt,
  input  logic [1:0]       req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state;
  logic        r_last;
  logic [31:0] r_a;
  logic [4:0]  r_b;
  logic [1:0]  r_c;
  logic        w_win0;
  logic        w_win1;
  logic        w_acc;
  logic [31:0] w_z;

  // Contended cycles go to the requester that did not win last time.
  assign w_win0     = req0_valid && (!req1_valid || r_last);
  assign w_win1     = req1_valid && (!req0_valid || !r_last);
  assign req0_ready = (r_state == IDLE) && !rst && w_win0;
  assign req1_ready = (r_state == IDLE) && !rst && w_win1;
  assign w_acc      = req0_ready || req1_ready;

  shifter u_shifter (
    .a (r_a),
    .b (r_b),
    .c (r_c),
    .z (w_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_a     <= req1_ready ? req1_data : req0_data;
            r_b     <= req1_ready ? req1_amt  : req0_amt;
            r_c     <= req1_ready ? req1_mode : req0_mode;
            rsp_id  <= req1_ready;
            r_last  <= req1_ready;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= w_z;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter; inputs driven and outputs sampled around negedge.
module tb_shift_arbiter;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [31:0]   req0_data, req1_data;
  logic [4:0]    req0_amt, req1_amt;
  logic [1:0]    req0_mode, req1_mode;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [31:0]   rsp_data;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  shift_arbiter #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic drive(input logic id, input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_mode = m;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_mode = m;
    end
  endtask

  // Single uncontended operation with rsp_ready high; starts and ends at an IDLE negedge.
  task automatic op(input logic id, input logic [31:0] d, input logic [4:0] a,
                    input logic [1:0] m, input logic [31:0] exp);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drive(id, d, a, m);
    #1;
    chk("acc_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    chk("acc_other", {31'd0, id ? req0_ready : req1_ready}, 32'd0);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, id});
    tick;
    chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] d;
    logic [4:0]  a;
    logic [1:0]  m;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   acc_cyc, prev_cyc;
  logic exp_id;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0001,  5'd4, 2'b00, 32'h0000_0010};
    vecs[1] = '{1'b1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 32'h1000_0000, 5'd31, 2'b11, 32'h2000_0000};
    vecs[3] = '{1'b1, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
    vecs[4] = '{1'b0, 32'hDEAD_BEEF,  5'd0, 2'b11, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 32'h8000_0001,  5'd0, 2'b10, 32'h8000_0001};
    vecs[6] = '{1'b0, 32'h0000_00F1,  5'd4, 2'b11, 32'h1000_000F};
    vecs[7] = '{1'b1, 32'h7000_0000,  5'd4, 2'b10, 32'h0700_0000};

    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req0_amt = '0; req0_mode = '0;
    req1_data = '0; req1_amt = '0; req1_mode = '0;
    tick;
    tick;
    req0_valid = 1'b1;
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_cnt", {28'd0, grant_cnt1, grant_cnt0}, 32'd0);
    tick;
    rst = 1'b0;
    req0_valid = 1'b0;

    foreach (vecs[i]) op(vecs[i].id, vecs[i].d, vecs[i].a, vecs[i].m, vecs[i].exp);

    // Contention straight after reset: grants alternate starting with requester 0.
    do_reset;
    drive(1'b0, 32'h0000_00F0, 5'd4, 2'b01);
    drive(1'b1, 32'h0000_000F, 5'd8, 2'b00);
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2) != 0;
      #1;
      chk("cont_win", {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
      acc_cyc = cyc;
      if (k > 0) chk("cont_gap", acc_cyc - prev_cyc, 32'd3);
      prev_cyc = acc_cyc;
      tick;
      #1;
      chk("cont_exec_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick;
      chk("cont_id", {31'd0, rsp_id}, {31'd0, exp_id});
      chk("cont_data", rsp_data, exp_id ? 32'h0000_0F00 : 32'h0000_000F);
      tick;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Back-pressure with requester 1 waiting.
    rsp_ready = 1'b0;
    drive(1'b0, 32'h0000_0003, 5'd1, 2'b00);
    #1;
    chk("bp_acc", {31'd0, req0_ready}, 32'd1);
    tick;
    req0_valid = 1'b0;
    drive(1'b1, 32'h0000_0100, 5'd8, 2'b01);
    #1;
    chk("bp_exec_rdy", {31'd0, req1_ready}, 32'd0);
    tick;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'h0000_0006);
      chk("bp_id", {31'd0, rsp_id}, 32'd0);
      chk("bp_rdy1", {31'd0, req1_ready}, 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_hs_rdy1", {31'd0, req1_ready}, 32'd0);
    tick;
    #1;
    chk("bp_next_acc", {31'd0, req1_ready}, 32'd1);
    tick;
    req1_valid = 1'b0;
    tick;
    chk("bp_next_data", rsp_data, 32'h0000_0001);
    chk("bp_next_id", {31'd0, rsp_id}, 32'd1);
    tick;

    // Reset during EXEC aborts the operation.
    drive(1'b0, 32'h0000_0001, 5'd1, 2'b00);
    tick;
    req0_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
    tick;
    chk("abort_valid2", {31'd0, rsp_valid}, 32'd0);
    op(1'b1, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);

    // Grant counters.
    do_reset;
    for (int k = 0; k < 5; k++) begin
      op(1'b0, 32'h0000_0004, 5'd2, 2'b01, 32'h0000_0001);
`ifdef SHIFT_ARB_STATS_EN
      if (k == 1) chk("cnt0_two", {30'd0, grant_cnt0}, 32'd2);
`else
      if (k == 1) chk("cnt0_two", {30'd0, grant_cnt0}, 32'd0);
`endif
    end
`ifdef SHIFT_ARB_STATS_EN
    chk("cnt0_sat", {30'd0, grant_cnt0}, 32'd3);
`else
    chk("cnt0_sat", {30'd0, grant_cnt0}, 32'd0);
`endif
    chk("cnt1", {30'd0, grant_cnt1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

- Shares one combinational 32-bit barrel shifter (`shifter`, ports a/b/c/z) between two requesters.
- Arbitrates round-robin, registers the winning operands, captures the shifter result and returns it on a valid/ready response channel tagged with the requester ID.
- Sits between the two execution-side clients and the shared `shifter` instance, which it instantiates internally.

## Interface
Parameters:
- `CNT_W`, 16: width of the per-requester grant counters (statistics build only).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_data`  in  32  operand.
- `req0_amt`  in  5  shift amount 0..31.
- `req0_mode`  in  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_amt`, `req1_mode`: same as requester 0.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  32  shifted result.
- `rsp_id`  out  1  requester that issued this result.
- `grant_cnt0`, `grant_cnt1`  out  CNT_W  accepted-request counts.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `reqN_valid` is high, pick a winner and assert only that requester's `reqN_ready`, combinationally, in the same cycle.
  - Latch its data/amt/mode into operand registers and its ID into `rsp_id`, then go to EXEC.
  - `reqN_ready` is 0 in every other state.
- Arbitration, using a 1-bit `last` pointer:
  - Only one requester valid: it wins.
  - Both valid: the requester != `last` wins.
  - `last` updates to the winner on every acceptance.
- EXEC:
  - The operand registers drive `shifter` a/b/c.
  - `z` is captured into `rsp_data`, then go to RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_data`/`rsp_id` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake, go to IDLE.
- Reset values:
  - Outputs: state=IDLE, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, both `reqN_ready`=0, grant counters 0.
  - `last`=1, so requester 0 wins the first contended cycle.
- Amount 0 in any mode returns the operand unchanged. Width is fixed at 32 bits, and the amount is never extended or truncated.
- Requester inputs are ignored outside IDLE. A requester that deasserts valid before acceptance is not served.
- `rst` asserted in EXEC or RESP aborts the in-flight operation: no response is produced and state returns to IDLE next cycle.

## Timing
- Request accepted in cycle N (IDLE, valid && ready).
- EXEC in cycle N+1.
- `rsp_valid` high from cycle N+2.
- Latency: 2 cycles, accept to `rsp_valid`.
- Best-case throughput: one operation per 3 cycles, with `rsp_ready` tied high. Next acceptance is at N+3.
- Back-pressure: each cycle `rsp_ready`=0 in RESP adds one cycle. No request is accepted until the response is taken.
- The `rsp_valid`/`rsp_ready` handshake and a new acceptance never occur in the same cycle.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Configuration
Macro `SHIFT_ARB_STATS_EN`:
- Defined:
  - `grant_cnt0`/`grant_cnt1` increment by 1 on each acceptance for that requester.
  - They saturate at all-ones; no wrap.
  - Cleared by `rst`.
- Undefined:
  - Counter logic is not built; both ports are driven constant 0.
  - All other behaviour is identical.

## Test plan
- Reset, then a single op:
  - Stimulus: `rst` for 2 cycles; then req0: data 32'h0000_0001, amt 4, mode 00; `rsp_ready`=1.
  - Required: `req0_ready` high on the accept cycle; `rsp_valid` exactly 2 cycles later with `rsp_data`=32'h0000_0010, `rsp_id`=0; one-cycle pulse.
- Arithmetic right:
  - Stimulus: req1: 32'h8000_0000, amt 31, mode 10.
  - Required: `rsp_data`=32'hFFFF_FFFF, `rsp_id`=1.
- Rotate right:
  - Stimulus: req0: 32'h1000_0000, amt 31, mode 11.
  - Required: `rsp_data`=32'h2000_0000.
- Contention:
  - Stimulus: both requesters held valid with distinct operands for 4 operations right after reset, `rsp_ready`=1.
  - Required: `rsp_id` sequence 0,1,0,1; acceptances 3 cycles apart.
- Back-pressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles in RESP while req1 is valid.
  - Required: `rsp_valid`, `rsp_data` and `rsp_id` held stable; `req1_ready`=0 throughout; req1 accepted the cycle after the handshake.
- Reset mid-flight and stats:
  - Stimulus: `rst` asserted during EXEC.
  - Required: no `rsp_valid`; IDLE next cycle.
  - With `SHIFT_ARB_STATS_EN` and CNT_W=2: 5 req0 ops give `grant_cnt0`=3 (saturated).
  - Without the macro: both counters read 0.
